// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode constants, fetch FSM state type and reset vector
package mips_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - combinational sequential/jump/branch next-PC select
module next_pc_logic #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-3:0] pcWord,
  input  logic [25:0]       instrLow,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero,
  output logic [ADDR_W-3:0] pcPlus4Word,
  output logic [ADDR_W-3:0] nextPCWord
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  // Working in word units keeps every target aligned without masking.
  logic [WORD_W-1:0] br_off;

  assign pcPlus4Word = pcWord + WORD_W'(1);
  assign br_off      = {{(WORD_W-16){instrLow[15]}}, instrLow[15:0]};

  always_comb begin
    nextPCWord = pcPlus4Word;
    if (Jump) begin
      nextPCWord = {pcPlus4Word[WORD_W-1:26], instrLow};
    end else if (Branch && Zero) begin
      nextPCWord = pcPlus4Word + br_off;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC ownership, imem request handshake, instruction hold
import mips_pkg::*;

module instr_fetch #(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcPlus4,
  input  logic              Jump,
  input  logic              Branch,
  input  logic              Zero
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-3:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-3:0] plus4_w, next_w;

  next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
    .pcWord      (pc_q),
    .instrLow    (instr_q[25:0]),
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .pcPlus4Word (plus4_w),
    .nextPCWord  (next_w)
  );

  // Request/valid are gated by reset so nothing leaks out during the reset cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imemReq    = 1'b0;
    instrValid = 1'b0;
    case (state_q)
      S_FETCH: begin
        imemReq = !reset;
        if (imemAck) begin
          instr_d = imemData;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        instrValid = !reset;
        if (instrReady) begin
          pc_d    = next_w;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC[ADDR_W-1:2];
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imemAddr = {pc_q, 2'b00};
  assign pc       = {pc_q, 2'b00};
  assign pcPlus4  = {plus4_w, 2'b00};
  assign instr    = instr_q;
  assign opCode   = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench: vector table, corner sequences, random vs reference model
import mips_pkg::*;

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        Jump, Branch, Zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_pc;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemAck    (imemAck),
    .imemData   (imemData),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instr      (instr),
    .opCode     (opCode),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        j, b, z;
    int          ack_dly, rdy_dly;
    logic [5:0]  exp_op;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // MIPS next-PC rules in plain 32-bit arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic j, input logic b, input logic z);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = p + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    if (j) return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
    if (b && z) return p4 + off * 32'd4;
    return p4;
  endfunction

  task automatic do_reset(input int n, input logic ack_during);
    reset      = 1'b1;
    imemAck    = ack_during;
    imemData   = 32'hFFFF_FFFF;
    instrReady = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_req", {31'b0, imemReq}, 32'd0);
      chk("rst_valid", {31'b0, instrValid}, 32'd0);
      tick();
    end
    reset   = 1'b0;
    imemAck = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, imemReq}, 32'd1);
    chk("post_rst_addr", imemAddr, 32'h0);
    chk("post_rst_valid", {31'b0, instrValid}, 32'd0);
    chk("post_rst_instr", instr, 32'h0);
    model_pc = 32'h0;
  endtask

  task automatic fetch_one(input logic [31:0] data, input logic j, input logic b, input logic z,
                           input int ack_dly, input int rdy_dly,
                           output logic [5:0] op_seen, output int cycles);
    int w;
    cycles = 0;
    w = 0;
    while (!imemReq && w < 8) begin
      tick();
      w++;
      cycles++;
    end
    chk("req_wait", {31'b0, imemReq}, 32'd1);
    chk("req_addr", imemAddr, model_pc);
    for (int i = 0; i < ack_dly; i++) begin
      imemAck = 1'b0;
      tick();
      cycles++;
      chk("req_hold_addr", imemAddr, model_pc);
      chk("req_hold_valid", {31'b0, instrValid}, 32'd0);
    end
    imemAck  = 1'b1;
    imemData = data;
    tick();
    cycles++;
    imemAck  = 1'b0;
    imemData = $urandom;
    chk("lat_valid", {31'b0, instrValid}, 32'd1);
    chk("instr", instr, data);
    chk("opcode", {26'b0, opCode}, {26'b0, data[31:26]});
    chk("pc", pc, model_pc);
    chk("pcplus4", pcPlus4, model_pc + 32'd4);
    op_seen = opCode;
    // Stalled: control inputs and stray acks are noise and must not disturb anything.
    for (int i = 0; i < rdy_dly; i++) begin
      instrReady = 1'b0;
      Jump       = 1'($urandom);
      Branch     = 1'($urandom);
      Zero       = 1'($urandom);
      imemAck    = 1'($urandom);
      imemData   = $urandom;
      tick();
      cycles++;
      chk("hold_instr", instr, data);
      chk("hold_pc", pc, model_pc);
      chk("hold_req", {31'b0, imemReq}, 32'd0);
      chk("hold_valid", {31'b0, instrValid}, 32'd1);
    end
    imemAck    = 1'b0;
    instrReady = 1'b1;
    Jump       = j;
    Branch     = b;
    Zero       = z;
    tick();
    cycles++;
    instrReady = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    model_pc   = ref_next(model_pc, data, j, b, z);
    chk("acc_valid", {31'b0, instrValid}, 32'd0);
    chk("next_addr", imemAddr, model_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]  op;
    int          cyc;
    logic [31:0] d;

    tbl[0] = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1, 0, OP_BEQ,   32'h0000_0000, 32'hFFFF_FFFC};
    tbl[1] = '{32'h8C01_0000, 1'b0, 1'b0, 1'b0, 1, 0, OP_LW,    32'hFFFF_FFFC, 32'h0000_0000};
    tbl[2] = '{32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, OP_RTYPE, 32'h0000_0000, 32'h0000_0004};
    tbl[3] = '{32'hAC22_0004, 1'b0, 1'b0, 1'b0, 1, 3, OP_SW,    32'h0000_0004, 32'h0000_0008};
    tbl[4] = '{32'h1000_0003, 1'b0, 1'b1, 1'b0, 1, 0, OP_BEQ,   32'h0000_0008, 32'h0000_000C};
    tbl[5] = '{32'h0800_0002, 1'b1, 1'b0, 1'b0, 0, 0, OP_J,     32'h0000_000C, 32'h0000_0008};
    tbl[6] = '{32'h1000_0003, 1'b0, 1'b1, 1'b1, 1, 0, OP_BEQ,   32'h0000_0008, 32'h0000_0018};
    tbl[7] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 1, 1, OP_J,     32'h0000_0018, 32'h0000_0100};
    tbl[8] = '{32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 2, 0, OP_BEQ,   32'h0000_0100, 32'h0000_0100};
    tbl[9] = '{32'h0800_0040, 1'b1, 1'b0, 1'b1, 1, 2, OP_J,     32'h0000_0100, 32'h0000_0100};

    reset      = 1'b1;
    imemAck    = 1'b0;
    imemData   = 32'h0;
    instrReady = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    model_pc   = 32'h0;
    tick();
    do_reset(2, 1'b0);

    for (int i = 0; i < 10; i++) begin
      chk("tbl_addr", imemAddr, tbl[i].exp_addr);
      fetch_one(tbl[i].data, tbl[i].j, tbl[i].b, tbl[i].z,
                tbl[i].ack_dly, tbl[i].rdy_dly, op, cyc);
      chk("tbl_opcode", {26'b0, op}, {26'b0, tbl[i].exp_op});
      chk("tbl_next", imemAddr, tbl[i].exp_next);
      if (tbl[i].ack_dly == 0 && tbl[i].rdy_dly == 0)
        chk("throughput", cyc, 32'd2);
    end

    // Reset while requesting at 0x100 with a coincident ack: the ack must be lost.
    chk("pre_rst_req", {31'b0, imemReq}, 32'd1);
    chk("pre_rst_addr", imemAddr, 32'h0000_0100);
    do_reset(1, 1'b1);
    tick();
    chk("rst_ack_dropped", {31'b0, instrValid}, 32'd0);
    chk("rst_refetch_addr", imemAddr, 32'h0);

    for (int i = 0; i < 60; i++) begin
      d = $urandom;
      fetch_one(d, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), op, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
